// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-through, write-allocate cache between a CPU
// request/ack bus and a memory request/ack bus, with flush and read counters.
// Ports: clk, rst (async, active-high); cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//   cpu_ack/cpu_rdata/cpu_hit/busy out; flush in; mem_req/mem_we/mem_addr/
//   mem_wdata out, mem_rdata/mem_ack in; hit_cnt/miss_cnt out.
// Latency: read hit acks one cycle after accept; miss/write ack the cycle
//   after mem_ack. cpu_req is only sampled while idle.
module dm_cache #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 7,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              busy,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t             state;
  logic               flush_pend;
  logic [LINES-1:0]   valid;

  // Line storage is deliberately not reset; only the valid bits are.
  logic [DATA_W-1:0]  data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               do_flush;
  logic               accept;
  logic               fill_done;

  logic               arr_we;
  logic [INDEX_W-1:0] arr_idx;
  logic [TAG_W-1:0]   arr_tag;
  logic [DATA_W-1:0]  arr_dat;

  assign req_idx  = cpu_addr[INDEX_W-1:0];
  assign req_tag  = cpu_addr[ADDR_W-1:INDEX_W];
  // mem_addr doubles as the captured request address for the refill.
  assign fill_idx = mem_addr[INDEX_W-1:0];
  assign fill_tag = mem_addr[ADDR_W-1:INDEX_W];

  assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  // A live or pending flush pre-empts any request in the same idle cycle.
  assign do_flush   = (state == IDLE) && (flush || flush_pend);
  assign accept     = (state == IDLE) && !do_flush && cpu_req;
  assign fill_done  = (state == FILL) && mem_ack;

  assign busy = (state != IDLE);

  // Single write port into the line arrays: write-allocate on accept, or refill.
  always_comb begin
    arr_we  = 1'b0;
    arr_idx = req_idx;
    arr_tag = req_tag;
    arr_dat = cpu_wdata;
    if (accept && cpu_we) begin
      arr_we = 1'b1;
    end else if (fill_done) begin
      arr_we  = 1'b1;
      arr_idx = fill_idx;
      arr_tag = fill_tag;
      arr_dat = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_mem[arr_idx] <= arr_dat;
      tag_mem[arr_idx]  <= arr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      valid      <= '0;
      cpu_ack    <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cpu_hit <= 1'b0;

      // Flush seen while busy waits for the next idle cycle.
      if (flush && (state != IDLE)) begin
        flush_pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (do_flush) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            if (cpu_we) begin
              valid[req_idx] <= 1'b1;
              mem_req        <= 1'b1;
              mem_we         <= 1'b1;
              state          <= WRITE;
            end else if (lookup_hit) begin
              cpu_rdata <= data_mem[req_idx];
              cpu_ack   <= 1'b1;
              cpu_hit   <= 1'b1;
              if (hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt <= hit_cnt + 1'b1;
              end
              state <= RESP;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              if (miss_cnt != {CNT_W{1'b1}}) begin
                miss_cnt <= miss_cnt + 1'b1;
              end
              state <= FILL;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[fill_idx] <= 1'b1;
            cpu_rdata       <= mem_rdata;
            mem_req         <= 1'b0;
            cpu_ack         <= 1'b1;
            state           <= RESP;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b1;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dm_cache.md
# dm_cache

Parametrised direct-mapped, write-through cache sitting between the CPU bus interface and the backing memory controller. It generalises the earlier 128 × 8 cache in address width, data width and depth. It adds per-line valid bits, a clocked request/acknowledge handshake on both sides, automatic miss refill, a flush command and saturating hit/miss counters.

## Interface
- ADDR_W, 16, address width in bits
- DATA_W, 8, data width in bits
- INDEX_W, 7, index bits; lines = 2^INDEX_W; tag width TAG_W = ADDR_W − INDEX_W
- CNT_W, 16, width of the statistics counters
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read; captured with cpu_req
- cpu_addr  in  ADDR_W  address; index = [INDEX_W−1:0], tag = [ADDR_W−1:INDEX_W]
- cpu_wdata  in  DATA_W  write data
- cpu_ack  out  1  one-cycle completion pulse (registered)
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1 on a read
- cpu_hit  out  1  1 = read hit, qualified by cpu_ack; 0 for misses and writes
- busy  out  1  state ≠ IDLE
- flush  in  1  invalidate all lines
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled on clk
- hit_cnt, miss_cnt  out  CNT_W  read hit and read-miss counts

## Operation
- Storage: data[2^INDEX_W], tag[2^INDEX_W], valid[2^INDEX_W].
  - rst clears valid only; data and tag arrays are not reset.
- FSM states: IDLE, FILL, WRITE, RESP.
- IDLE:
  - Priority: flush (or pending flush) > cpu_req.
  - Flush clears every valid bit at that edge and stays in IDLE. No ack is issued.
  - On cpu_req, capture we/addr/wdata.
  - Read with valid[idx] and tag[idx] == addr tag: latch data, hit_r=1, go to RESP.
  - Read otherwise (miss): go to FILL.
  - Write: go to WRITE. On the accepting edge, update data, tag and valid=1 (write-allocate).
- FILL:
  - Drive mem_req=1, mem_we=0, mem_addr=captured addr.
  - On the mem_ack edge: write mem_rdata into the line, set tag, set valid=1, latch rdata, hit_r=0, go to RESP.
- WRITE:
  - Drive mem_req=1, mem_we=1, mem_addr/mem_wdata = captured values.
  - On the mem_ack edge, go to RESP with hit_r=0.
- RESP: cpu_ack=1 for exactly one cycle, then IDLE.
- Counters:
  - Increment on the accept edge of a read only: hit_cnt on a hit, miss_cnt on a miss.
  - Both saturate at 2^CNT_W−1 and are cleared only by rst.
- Flush while busy is latched as pending. It is executed on the first IDLE cycle, before any cpu_req.
- cpu_req while busy is ignored. The requester must drop cpu_req in the cycle after cpu_ack, or it is taken as a new request.
- mem_ack outside FILL/WRITE is ignored.

## Timing
- Reset values:
  - Outputs: cpu_ack, cpu_hit, busy, mem_req, mem_we = 0; cpu_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt = 0.
  - State: IDLE, flush pending = 0, all lines invalid.
- Read hit: accept at edge 0; cpu_ack=1 in cycle 1; IDLE in cycle 2. Sustained rate is one hit per 2 cycles.
- Read miss or write: mem_req rises in cycle 1.
  - If mem_ack is seen at edge k, cpu_ack=1 in cycle k+1.
  - Minimum latency is 3 cycles: accept, FILL/WRITE, RESP.
- mem_req, mem_we, mem_addr and mem_wdata are registered and stable until the mem_ack edge. mem_req drops the cycle after ack.
- A write to an index overwrites any previous tag/data at that index, hit or not.
- A read at the same index after a write to a different tag misses.
- Reset mid-FILL/WRITE:
  - Returns to IDLE asynchronously and drops mem_req immediately.
  - The outstanding transaction is abandoned, with no cpu_ack.
  - Valid bits are cleared.

## Test plan
- Reset, then read 0x1234 with memory returning 0xA5 after 3 wait cycles → mem_req held 4 cycles; cpu_ack with rdata=0xA5, hit=0; miss_cnt=1.
- Read 0x1234 again → cpu_ack in cycle 1 with rdata=0xA5, hit=1, no mem_req; hit_cnt=1.
- Write 0x5555←0x3C → mem write issued with mem_addr=0x5555, mem_wdata=0x3C. Then read 0x5555 → hit, 0x3C. Then read 0x1255 (same index, other tag) → miss.
- Flush asserted during a FILL → the fill completes and is acked. The flush then executes, and the next read of that address misses.
- rst asserted mid-WRITE → mem_req and busy drop immediately, no ack; a following read of any prior address misses.
- With CNT_W=2: 5 hits → hit_cnt saturates at 3.
